// File: rtl/cvif_read_ig_bpt_splitter_pkg.sv
// Shared definitions for the CVIF read-ingress burst partitioner.
//   ATOM_BYTES   : size of one DMA atom in bytes
//   DMA_*        : field layout of dma2bpt_req_pd  {size[14:0], addr[63:0]}
//   BPT_*        : field layout of bpt2arb_req8_pd {axid,ftran,ltran,odd,swizzle,len,addr}
//   bpt_state_e  : partitioner FSM states
package cvif_rd_ig_pkg;

  localparam int unsigned ATOM_BYTES    = 32;
  localparam int unsigned REM_W         = 16;

  localparam int unsigned DMA_PD_W      = 79;
  localparam int unsigned DMA_ADDR_LSB  = 0;
  localparam int unsigned DMA_ADDR_W    = 64;
  localparam int unsigned DMA_SIZE_LSB  = 64;
  localparam int unsigned DMA_SIZE_W    = 15;

  localparam int unsigned BPT_PD_W      = 75;
  localparam int unsigned BPT_ADDR_LSB  = 0;
  localparam int unsigned BPT_ADDR_W    = 64;
  localparam int unsigned BPT_LEN_LSB   = 64;
  localparam int unsigned BPT_LEN_W     = 3;
  localparam int unsigned BPT_SWZ_BIT   = 67;
  localparam int unsigned BPT_ODD_BIT   = 68;
  localparam int unsigned BPT_LTRAN_BIT = 69;
  localparam int unsigned BPT_FTRAN_BIT = 70;
  localparam int unsigned BPT_AXID_LSB  = 71;
  localparam int unsigned BPT_AXID_W    = 4;

  typedef enum logic {
    BPT_IDLE,
    BPT_SPLIT
  } bpt_state_e;

endpackage

// File: rtl/cvif_read_ig_bpt_splitter_len_calc.sv
// Combinational burst sizing for the read-ingress partitioner.
//   idx       : atom index of the burst address inside its MAX_ATOMS*32B window
//   remaining : atoms still to be issued for the current request (>= 1)
//   first     : burst is the first of its request
//   atoms     : atoms in this burst (1..MAX_ATOMS)
//   len       : atoms-1
//   odd       : atoms[0]
//   swizzle   : burst address bit 5
//   ltran     : this burst finishes the request
module cvif_read_ig_bpt_len_calc
  import cvif_rd_ig_pkg::*;
#(
  parameter int unsigned MAX_ATOMS = 8,
  parameter int unsigned IDX_W     = $clog2(MAX_ATOMS)
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [REM_W-1:0] remaining,
  input  logic             first,
  output logic [IDX_W:0]   atoms,
  output logic [IDX_W-1:0] len,
  output logic             odd,
  output logic             swizzle,
  output logic             ltran
);

  localparam logic [IDX_W:0] CAP_FULL = (IDX_W+1)'(MAX_ATOMS);

  logic [IDX_W:0] cap;

  always_comb begin
    // Only the first burst can start mid-window; later ones are window aligned.
    cap   = first ? (CAP_FULL - {1'b0, idx}) : CAP_FULL;
    atoms = (remaining < REM_W'(cap)) ? remaining[IDX_W:0] : cap;
  end

  // Modular subtraction on the low bits maps MAX_ATOMS to all-ones.
  assign len     = atoms[IDX_W-1:0] - IDX_W'(1);
  assign odd     = atoms[0];
  assign swizzle = idx[0];
  assign ltran   = (REM_W'(atoms) == remaining);

endmodule

// File: rtl/cvif_read_ig_bpt_splitter.sv
// Read-ingress burst partitioner for CVIF source port 8.
// Accepts one DMA read request and splits it into bursts of at most MAX_ATOMS
// 32B atoms, none crossing a MAX_ATOMS*32B boundary.
//   nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//   dma2bpt_req_valid/ready/pd       : request in {size=atoms-1, addr}
//   bpt2arb_req8_valid/ready/pd      : registered burst out to the port-8 skid stage
module cvif_read_ig_bpt_splitter
  import cvif_rd_ig_pkg::*;
#(
  parameter int unsigned           MAX_ATOMS = 8,
  parameter logic [BPT_AXID_W-1:0] AXID      = 4'd8
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rstn,
  input  logic                dma2bpt_req_valid,
  output logic                dma2bpt_req_ready,
  input  logic [DMA_PD_W-1:0] dma2bpt_req_pd,
  output logic                bpt2arb_req8_valid,
  input  logic                bpt2arb_req8_ready,
  output logic [BPT_PD_W-1:0] bpt2arb_req8_pd
);

  localparam int unsigned IDX_W     = $clog2(MAX_ATOMS);
  localparam int unsigned ATM_SHIFT = $clog2(ATOM_BYTES);

  bpt_state_e state_q, state_d;

  logic [BPT_ADDR_W-1:0] addr_q;
  logic [REM_W-1:0]      rem_q;
  logic                  valid_q;
  logic [BPT_PD_W-1:0]   pd_q;

  logic                  dma_fire;
  logic                  out_fire;
  logic                  is_last;
  logic                  load;
  logic [DMA_SIZE_W-1:0] dma_size;
  logic [BPT_ADDR_W-1:0] dma_addr;
  logic [ATM_SHIFT-1:0]  unused_addr_lsb;

  logic [BPT_ADDR_W-1:0] calc_addr;
  logic [REM_W-1:0]      calc_rem;
  logic                  calc_first;
  logic [BPT_ADDR_W-1:0] next_addr;
  logic [REM_W-1:0]      next_rem;
  logic [BPT_PD_W-1:0]   burst_pd;

  logic [IDX_W:0]        atoms;
  logic [IDX_W-1:0]      len;
  logic                  odd;
  logic                  swizzle;
  logic                  ltran;

  assign dma_size        = dma2bpt_req_pd[DMA_SIZE_LSB +: DMA_SIZE_W];
  assign dma_addr        = {dma2bpt_req_pd[DMA_ADDR_LSB+ATM_SHIFT +: DMA_ADDR_W-ATM_SHIFT],
                            {ATM_SHIFT{1'b0}}};
  assign unused_addr_lsb = dma2bpt_req_pd[DMA_ADDR_LSB +: ATM_SHIFT];

  assign is_last           = pd_q[BPT_LTRAN_BIT];
  assign out_fire          = valid_q && bpt2arb_req8_ready;
  assign dma2bpt_req_ready = (state_q == BPT_IDLE) || (out_fire && is_last);
  assign dma_fire          = dma2bpt_req_valid && dma2bpt_req_ready;
  // A new burst enters the output register either from a fresh request or
  // from the running counters as the current burst leaves (no bubble).
  assign load              = dma_fire || (out_fire && !is_last);

  always_comb begin
    calc_first = dma_fire;
    calc_addr  = addr_q;
    calc_rem   = rem_q;
    if (dma_fire) begin
      calc_addr = dma_addr;
      calc_rem  = {1'b0, dma_size} + REM_W'(1);
    end
  end

  cvif_read_ig_bpt_len_calc #(
    .MAX_ATOMS (MAX_ATOMS),
    .IDX_W     (IDX_W)
  ) u_len_calc (
    .idx       (calc_addr[ATM_SHIFT +: IDX_W]),
    .remaining (calc_rem),
    .first     (calc_first),
    .atoms     (atoms),
    .len       (len),
    .odd       (odd),
    .swizzle   (swizzle),
    .ltran     (ltran)
  );

  assign next_addr = calc_addr + (BPT_ADDR_W'(atoms) << ATM_SHIFT);
  assign next_rem  = calc_rem - REM_W'(atoms);

  always_comb begin
    burst_pd                                  = '0;
    burst_pd[BPT_ADDR_LSB +: BPT_ADDR_W]      = calc_addr;
    burst_pd[BPT_LEN_LSB +: BPT_LEN_W]        = len;
    burst_pd[BPT_SWZ_BIT]                     = swizzle;
    burst_pd[BPT_ODD_BIT]                     = odd;
    burst_pd[BPT_LTRAN_BIT]                   = ltran;
    burst_pd[BPT_FTRAN_BIT]                   = calc_first;
    burst_pd[BPT_AXID_LSB +: BPT_AXID_W]      = AXID;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BPT_IDLE:  if (dma_fire) state_d = BPT_SPLIT;
      BPT_SPLIT: if (out_fire && is_last && !dma_fire) state_d = BPT_IDLE;
      default:   state_d = BPT_IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q <= BPT_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      pd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        valid_q <= 1'b1;
        pd_q    <= burst_pd;
        addr_q  <= next_addr;
        rem_q   <= next_rem;
      end else if (out_fire) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bpt2arb_req8_valid = valid_q;
  assign bpt2arb_req8_pd    = pd_q;

endmodule

// File: tb/tb_cvif_read_ig_bpt_splitter.sv
module tb_cvif_read_ig_bpt_splitter;

  logic        clk;
  logic        rstn;
  logic        dma_valid;
  logic        dma_ready;
  logic [78:0] dma_pd;
  logic        out_valid;
  logic        out_ready;
  logic [74:0] out_pd;

  int tests;
  int fails;

  cvif_read_ig_bpt_splitter #(
    .MAX_ATOMS (8),
    .AXID      (4'd8)
  ) dut (
    .nvdla_core_clk     (clk),
    .nvdla_core_rstn    (rstn),
    .dma2bpt_req_valid  (dma_valid),
    .dma2bpt_req_ready  (dma_ready),
    .dma2bpt_req_pd     (dma_pd),
    .bpt2arb_req8_valid (out_valid),
    .bpt2arb_req8_ready (out_ready),
    .bpt2arb_req8_pd    (out_pd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

  function automatic logic [74:0] mkpd(input logic f, input logic l, input logic o,
                                       input logic s, input logic [2:0] ln,
                                       input logic [63:0] a);
    return {4'd8, f, l, o, s, ln, a};
  endfunction

  task automatic chk(input string tag, input logic [74:0] obs, input logic [74:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge. Held bursts
  // are checked for stability whenever the previous cycle stalled.
  task automatic tick();
    logic        pv, pr, prst;
    logic [74:0] ppd;
    pv   = out_valid;
    pr   = out_ready;
    ppd  = out_pd;
    prst = rstn;
    @(posedge clk);
    #1;
    if (prst && rstn && pv && !pr) begin
      chk("hold_valid", 75'(out_valid), 75'(1));
      chk("hold_pd", out_pd, ppd);
    end
  endtask

  task automatic req(input logic [63:0] a, input logic [14:0] sz);
    dma_pd    = {sz, a};
    dma_valid = 1'b1;
  endtask

  int  n;
  logic done;

  initial begin
    tests     = 0;
    fails     = 0;
    rstn      = 1'b0;
    dma_valid = 1'b0;
    dma_pd    = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_valid", 75'(out_valid), 75'(0));
    chk("rst_dma_ready", 75'(dma_ready), 75'(1));
    chk("rst_pd", out_pd, 75'(0));
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // 1: size 0 -> one 1-atom burst
    req(64'h1000_0040, 15'd0);
    out_ready = 1'b1;
    #1;
    chk("t1_dma_ready_idle", 75'(dma_ready), 75'(1));
    tick();
    dma_valid = 1'b0;
    #1;
    chk("t1_valid", 75'(out_valid), 75'(1));
    chk("t1_pd", out_pd, mkpd(1, 1, 1, 0, 3'd0, 64'h1000_0040));
    chk("t1_dma_ready", 75'(dma_ready), 75'(1));
    tick();
    chk("t1_done", 75'(out_valid), 75'(0));

    // 2: unaligned 10 atoms -> 1 + 8 + 1
    req(64'h1000_00E0, 15'd9);
    tick();
    dma_valid = 1'b0;
    #1;
    chk("t2_b0", out_pd, mkpd(1, 0, 1, 1, 3'd0, 64'h1000_00E0));
    chk("t2_dma_ready_b0", 75'(dma_ready), 75'(0));
    tick();
    chk("t2_b1", out_pd, mkpd(0, 0, 0, 0, 3'd7, 64'h1000_0100));
    tick();
    chk("t2_b2", out_pd, mkpd(0, 1, 1, 0, 3'd0, 64'h1000_0200));
    tick();
    chk("t2_done", 75'(out_valid), 75'(0));

    // 3: aligned exactly MAX_ATOMS -> single burst
    req(64'h2000, 15'd7);
    tick();
    dma_valid = 1'b0;
    #1;
    chk("t3_b0", out_pd, mkpd(1, 1, 0, 0, 3'd7, 64'h2000));
    tick();
    chk("t3_done", 75'(out_valid), 75'(0));

    // 4: 32 atoms with ready toggling
    req(64'h3000, 15'd31);
    out_ready = 1'b0;
    tick();
    dma_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [74:0] e;
      e = mkpd(k == 0, k == 3, 0, 0, 3'd7, 64'h3000 + 64'(k) * 64'h100);
      out_ready = 1'b0;
      #1;
      chk("t4_stall_pd", out_pd, e);
      chk("t4_stall_dma_ready", 75'(dma_ready), 75'(0));
      tick();
      out_ready = 1'b1;
      #1;
      chk("t4_go_pd", out_pd, e);
      chk("t4_go_dma_ready", 75'(dma_ready), 75'(k == 3));
      tick();
    end
    chk("t4_done", 75'(out_valid), 75'(0));

    // 5: back-to-back requests, second pd presented while not ready
    req(64'h4000, 15'd15);
    tick();
    req(64'h5020, 15'd2);
    #1;
    chk("t5_a0", out_pd, mkpd(1, 0, 0, 0, 3'd7, 64'h4000));
    chk("t5_a0_dma_ready", 75'(dma_ready), 75'(0));
    tick();
    chk("t5_a1", out_pd, mkpd(0, 1, 0, 0, 3'd7, 64'h4100));
    chk("t5_a1_dma_ready", 75'(dma_ready), 75'(1));
    tick();
    dma_valid = 1'b0;
    #1;
    chk("t5_b_valid", 75'(out_valid), 75'(1));
    chk("t5_b0", out_pd, mkpd(1, 1, 1, 1, 3'd2, 64'h5020));
    tick();
    chk("t5_done", 75'(out_valid), 75'(0));

    // 6: reset after 2 of 4 bursts
    req(64'h6000, 15'd31);
    tick();
    dma_valid = 1'b0;
    #1;
    chk("t6_b0", out_pd, mkpd(1, 0, 0, 0, 3'd7, 64'h6000));
    tick();
    chk("t6_b1", out_pd, mkpd(0, 0, 0, 0, 3'd7, 64'h6100));
    tick();
    rstn = 1'b0;
    #1;
    chk("t6_rst_valid", 75'(out_valid), 75'(0));
    chk("t6_rst_dma_ready", 75'(dma_ready), 75'(1));
    chk("t6_rst_pd", out_pd, 75'(0));
    tick();
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_no_stale", 75'(out_valid), 75'(0));
    end

    // address wrap
    req(64'hFFFF_FFFF_FFFF_FFE0, 15'd1);
    tick();
    dma_valid = 1'b0;
    #1;
    chk("wrap_b0", out_pd, mkpd(1, 0, 1, 1, 3'd0, 64'hFFFF_FFFF_FFFF_FFE0));
    tick();
    chk("wrap_b1", out_pd, mkpd(0, 1, 1, 0, 3'd0, 64'h0));
    tick();
    chk("wrap_done", 75'(out_valid), 75'(0));

    // max size, aligned then unaligned
    for (int u = 0; u < 2; u++) begin
      req((u == 0) ? 64'h0 : 64'h20, 15'h7FFF);
      tick();
      dma_valid = 1'b0;
      n    = 0;
      done = 1'b0;
      for (int c = 0; c < 5000 && !done; c++) begin
        if (out_valid) begin
          n++;
          if (out_pd[69]) done = 1'b1;
        end
        tick();
      end
      chk("max_done", 75'(done), 75'(1));
      chk("max_count", 75'(n), (u == 0) ? 75'(4096) : 75'(4097));
      chk("max_idle", 75'(out_valid), 75'(0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
